// File: rtl/rgb_hue_fader_pkg.sv
// Shared types and constants for the RGB hue-wheel fader.
// Holds the wheel segment encoding and the per-segment channel roles.
package rgb_hue_fader_pkg;

  localparam int NUM_SEGMENTS = 6;

  typedef enum logic [2:0] {
    SEG_R_TO_Y = 3'd0,
    SEG_Y_TO_G = 3'd1,
    SEG_G_TO_C = 3'd2,
    SEG_C_TO_B = 3'd3,
    SEG_B_TO_M = 3'd4,
    SEG_M_TO_R = 3'd5
  } segment_e;

  // What a channel's duty follows within a segment.
  typedef enum logic [1:0] {
    ROLE_ZERO = 2'd0,
    ROLE_MAX  = 2'd1,
    ROLE_UP   = 2'd2,
    ROLE_DOWN = 2'd3
  } role_e;

  // Channel index: 0 = R, 1 = G, 2 = B.
  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

  // Role of one channel in one segment of the wheel.
  function automatic role_e seg_role(input segment_e s, input int ch);
    role_e r;
    r = ROLE_ZERO;
    case (s)
      SEG_R_TO_Y: r = (ch == CH_R) ? ROLE_MAX  : (ch == CH_G) ? ROLE_UP   : ROLE_ZERO;
      SEG_Y_TO_G: r = (ch == CH_R) ? ROLE_DOWN : (ch == CH_G) ? ROLE_MAX  : ROLE_ZERO;
      SEG_G_TO_C: r = (ch == CH_R) ? ROLE_ZERO : (ch == CH_G) ? ROLE_MAX  : ROLE_UP;
      SEG_C_TO_B: r = (ch == CH_R) ? ROLE_ZERO : (ch == CH_G) ? ROLE_DOWN : ROLE_MAX;
      SEG_B_TO_M: r = (ch == CH_R) ? ROLE_UP   : (ch == CH_G) ? ROLE_ZERO : ROLE_MAX;
      SEG_M_TO_R: r = (ch == CH_R) ? ROLE_MAX  : (ch == CH_G) ? ROLE_ZERO : ROLE_DOWN;
      default:    r = ROLE_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rgb_hue_fader_channel.sv
// One PWM channel: optional gamma stage then registered active-low drive.
// Build option: RGB_HUE_FADER_GAMMA_EN squares the duty (full scale kept).
module rgb_pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] eff;

`ifdef RGB_HUE_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq  = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};
  // Full scale must stay solidly on, so MAX bypasses the square.
  assign eff = (duty == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign eff = duty;
`endif

  // Active-low pin: lit for duty MAX, or while the PWM count is below duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led <= 1'b1;
    else        led <= ~((eff == MAX) || (pwm_cnt < eff));
  end

endmodule

// File: rtl/rgb_hue_fader.sv
// RGB hue-wheel driver: prescaler, level/segment walk, shared PWM counter
// and three PWM channels. Gamma option: RGB_HUE_FADER_GAMMA_EN.
module rgb_hue_fader
  import rgb_hue_fader_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int STEP_INTERVAL = 7812
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       mode,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic [2:0] segment,
  output logic       seg_wrap
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam int PW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_INTERVAL - 1);

  logic [PW-1:0]             pre_cnt;
  logic [PWM_BITS-1:0]       level;
  logic [PWM_BITS-1:0]       pwm_cnt;
  segment_e                  seg;
  logic                      tick;
  logic [2:0][PWM_BITS-1:0]  duty;
  logic [2:0]                led;

  assign tick = enable && (pre_cnt == PRE_LAST);

  // Prescaler and wheel position; everything freezes while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      level    <= '0;
      seg      <= SEG_R_TO_Y;
      seg_wrap <= 1'b0;
    end else begin
      seg_wrap <= 1'b0;
      if (tick) begin
        pre_cnt <= '0;
        if (level != MAX) begin
          level <= level + 1'b1;
        end else begin
          level <= '0;
          if (seg == SEG_M_TO_R) begin
            seg      <= SEG_R_TO_Y;
            seg_wrap <= 1'b1;
          end else begin
            seg <= segment_e'(seg + 3'd1);
          end
        end
      end else if (enable) begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  // Free-running PWM base, independent of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Per-channel duty from the segment role; hard-step mode pins ramps to endpoints.
  always_comb begin
    duty = '0;
    for (int ch = 0; ch < 3; ch++) begin
      case (seg_role(seg, ch))
        ROLE_MAX:  duty[ch] = MAX;
        ROLE_UP:   duty[ch] = mode ? level : '0;
        ROLE_DOWN: duty[ch] = mode ? (MAX - level) : MAX;
        default:   duty[ch] = '0;
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .duty    (duty[g]),
      .pwm_cnt (pwm_cnt),
      .led     (led[g])
    );
  end

  assign RGB_R   = led[CH_R];
  assign RGB_G   = led[CH_G];
  assign RGB_B   = led[CH_B];
  assign segment = seg;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Bench for rgb_hue_fader (PWM_BITS=4, STEP_INTERVAL=2). A model tracks the
// count of enabled clocks and derives level/segment/PWM from it arithmetically.
module tb_rgb_hue_fader;

  localparam int PB   = 4;
  localparam int SI   = 2;
  localparam int LV   = 1 << PB;   // levels per segment
  localparam int MAXD = LV - 1;
  localparam int WHEEL = SI * LV * 6;

  // Role table per segment, channels R,G,B: 0 zero, 1 max, 2 ramp-up, 3 ramp-down.
  localparam int ROLES [6][3] = '{'{1,2,0}, '{3,1,0}, '{0,1,2},
                                   '{0,3,1}, '{2,0,1}, '{1,0,3}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic mode = 1'b0;
  logic RGB_R, RGB_G, RGB_B, seg_wrap;
  logic [2:0] segment;

  int n_cmp = 0;
  int n_bad = 0;

  rgb_hue_fader #(.PWM_BITS(PB), .STEP_INTERVAL(SI)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
    .segment(segment), .seg_wrap(seg_wrap)
  );

  initial forever #5 clk = ~clk;

  function automatic int eff_duty(input int sg, input int ch, input int lvl, input bit md);
    int d;
    case (ROLES[sg][ch])
      1:       d = MAXD;
      2:       d = md ? lvl : 0;
      3:       d = md ? (MAXD - lvl) : MAXD;
      default: d = 0;
    endcase
`ifdef RGB_HUE_FADER_GAMMA_EN
    if (d != MAXD) d = (d * d) >> PB;
`endif
    return d;
  endfunction

  // Model state: enabled clocks and total clocks since reset.
  int m_en = 0;
  int m_edges = 0;
  logic [2:0] exp_led = 3'b111;   // {B,G,R}
  int exp_seg = 0;
  bit exp_wrap = 1'b0;
  int stp, lvl, sg, pw, d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_edges = 0; exp_led = 3'b111; exp_seg = 0; exp_wrap = 1'b0;
    end else begin
      stp = m_en / SI; lvl = stp % LV; sg = (stp / LV) % 6; pw = m_edges % LV;
      for (int ch = 0; ch < 3; ch++) begin
        d = eff_duty(sg, ch, lvl, mode);
        exp_led[ch] = !(d == MAXD || pw < d);
      end
      if (enable) m_en++;
      m_edges++;
      exp_wrap = enable && (m_en % WHEEL == 0);
      exp_seg  = ((m_en / SI) / LV) % 6;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    n_cmp++;
    if ({RGB_B, RGB_G, RGB_R} !== exp_led) begin
      n_bad++;
      $display("FAIL leds t=%0t: got %b expected %b (BGR)", $time, {RGB_B, RGB_G, RGB_R}, exp_led);
    end
    n_cmp++;
    if (segment !== 3'(exp_seg)) begin
      n_bad++;
      $display("FAIL segment t=%0t: got %0d expected %0d", $time, segment, exp_seg);
    end
    n_cmp++;
    if (seg_wrap !== exp_wrap) begin
      n_bad++;
      $display("FAIL seg_wrap t=%0t: got %0d expected %0d", $time, seg_wrap, exp_wrap);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Count over 16 clocks: lit R, lit G, dark B.
  task automatic measure(output int r_lit, output int g_lit, output int b_dark);
    r_lit = 0; g_lit = 0; b_dark = 0;
    repeat (LV) begin
      cyc();
      r_lit  += (RGB_R == 1'b0);
      g_lit  += (RGB_G == 1'b0);
      b_dark += (RGB_B == 1'b1);
    end
  endtask

  task automatic run_until_en(input int target, input string name);
    int guard;
    guard = 0;
    while (m_en != target && guard < 1000) begin cyc(); guard++; end
    chk({name, "_reached"}, m_en, target);
  endtask

  int wraps, rl, gl, bd, guard;

  initial begin
    // Held in reset: all dark, segment 0.
    repeat (3) cyc();
    chk("reset_leds", {RGB_B, RGB_G, RGB_R}, 3'b111);
    chk("reset_seg", segment, 0);
    chk("reset_wrap", seg_wrap, 0);

    // Hard-step mode across one full wheel.
    rst_n = 1'b1;
    wraps = 0;
    for (int c = 1; c <= 192; c++) begin
      cyc();
      wraps += seg_wrap;
      if (c == 1)   chk("first_edge_red", {RGB_B, RGB_G, RGB_R}, 3'b110);
      if (c == 32)  chk("seg1_at_32", segment, 1);
      if (c == 33)  chk("yellow_at_33", {RGB_B, RGB_G, RGB_R}, 3'b100);
      if (c == 192) chk("wrap_at_192", seg_wrap, 1);
    end
    chk("wrap_count", wraps, 1);

    // Smooth mode, freeze at level 8 of segment 0 (held 100 clocks).
    mode = 1'b1;
    run_until_en(WHEEL + 8 * SI, "lvl8");
    enable = 1'b0;
    cyc();
    measure(rl, gl, bd);
`ifdef RGB_HUE_FADER_GAMMA_EN
    chk("lvl8_g_lit", gl, 4);
`else
    chk("lvl8_g_lit", gl, 8);
`endif
    chk("lvl8_r_lit", rl, 16);
    chk("lvl8_b_dark", bd, 16);
    repeat (83) cyc();
    chk("frozen_seg", segment, 0);
    enable = 1'b1;

    // End of segment 1 (level 15): R off, G solid.
    run_until_en(WHEEL + (LV + MAXD) * SI, "seg1_end");
    enable = 1'b0;
    cyc();
    measure(rl, gl, bd);
    chk("seg1end_r_lit", rl, 0);
    chk("seg1end_g_lit", gl, 16);
    chk("seg1end_seg", segment, 1);
    enable = 1'b1;

    // Asynchronous reset while in segment 3.
    guard = 0;
    while (exp_seg != 3 && guard < 1000) begin cyc(); guard++; end
    chk("reach_seg3", segment, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_leds", {RGB_B, RGB_G, RGB_R}, 3'b111);
    chk("async_rst_seg", segment, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("after_rst_red", {RGB_B, RGB_G, RGB_R}, 3'b110);

    // Level 15 in segment 0: G full scale, solid in either build.
    run_until_en(MAXD * SI, "lvl15");
    enable = 1'b0;
    cyc();
    measure(rl, gl, bd);
    chk("lvl15_g_lit", gl, 16);
    chk("lvl15_r_lit", rl, 16);
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
